pingpong_rd_scheduler: RTL

- Read-side controller for the ping-pong FIFO banks filled by the pre-filter writer. Bank A is the FIFO pair written by wr1/wr2; bank B is the pair written by wr3/wr4.
- Counts the write strobes into each bank and marks a bank full after one line of packer_len samples.
- Drains full banks to the downstream droplet-detection stage in completion order, under a proc_rdy back-pressure handshake.
- Flags overrun when the writer targets a bank that has not yet been drained.

---
 rtl/pingpong_rd_scheduler_pkg.sv | 17 +
 rtl/pingpong_rd_scheduler_bank_fill_tracker.sv | 56 +++++
 rtl/pingpong_rd_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pingpong_rd_scheduler_pkg.sv
// Shared types and constants for the ping-pong FIFO read scheduler.
// State encoding, bank identifiers and default widths.
package pingpong_pkg;

    localparam int LEN_W_DEF  = 13;
    localparam int LCNT_W_DEF = 16;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pingpong_rd_scheduler_bank_fill_tracker.sv
// Per-bank write counter: raises full one cycle after the len_q-th write.
// A write that lands on a full bank is dropped and pulses ovr_pulse (comb).
module bank_fill_tracker
    import pingpong_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr,
    input  logic             drain_done,
    input  logic [LEN_W-1:0] len_q,
    output logic             full,
    output logic             ovr_pulse
);

    logic [LEN_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic             full_q, full_d;
    logic             still_full;

    always_comb begin
        // A drain finishing this cycle frees the bank for a same-cycle write
        still_full = full_q & ~drain_done;
        wcnt_inc   = wcnt_q + 1'b1;
        wcnt_d     = wcnt_q;
        full_d     = still_full;
        ovr_pulse  = 1'b0;
        if (flush) begin
            wcnt_d = '0;
            full_d = 1'b0;
        end else if (wr) begin
            if (still_full) begin
                ovr_pulse = 1'b1;
            end else if (wcnt_inc == len_q) begin
                wcnt_d = '0;
                full_d = 1'b1;
            end else begin
                wcnt_d = wcnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
            full_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            full_q <= full_d;
        end
    end

    assign full = full_q;

endmodule

// File: rtl/pingpong_rd_scheduler.sv
// Drains full ping-pong banks A/B in completion order; first read 2 cycles after the last write.
// Reads are gated combinationally by proc_rdy; a stalled drain holds state and read count.
module pingpong_rd_scheduler
    import pingpong_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int LCNT_W = LCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LEN_W-1:0]  packer_len,
    input  logic              wr_a,
    input  logic              wr_b,
    input  logic              proc_rdy,
    output logic              rd_a,
    output logic              rd_b,
    output logic              bank_sel,
    output logic              line_start,
    output logic              line_end,
    output logic              busy,
    output logic              overrun,
    output logic [LCNT_W-1:0] lines_done
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rcnt_q, rcnt_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              overrun_q, overrun_d;
    logic [LCNT_W-1:0] lines_q, lines_d;

    logic             start, flush, rd_go, last_rd, full_sel;
    logic             full_a, full_b, ovr_a, ovr_b;
    logic [LEN_W-1:0] len_m1;

    assign start    = (state_q == ST_IDLE) & enable;
    assign flush    = (state_q == ST_IDLE) | ~enable;
    assign full_sel = (rd_ptr_q == BANK_B) ? full_b : full_a;
    assign len_m1   = len_q - 1'b1;
    // Reset and enable both cut the strobe immediately so an abort never reads once more
    assign rd_go    = (state_q == ST_DRAIN) & proc_rdy & enable & ~reset;
    assign last_rd  = rd_go & (rcnt_q == len_m1);

    bank_fill_tracker #(.LEN_W(LEN_W)) u_fill_a (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr         (wr_a),
        .drain_done (last_rd & (rd_ptr_q == BANK_A)),
        .len_q      (len_q),
        .full       (full_a),
        .ovr_pulse  (ovr_a)
    );

    bank_fill_tracker #(.LEN_W(LEN_W)) u_fill_b (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr         (wr_b),
        .drain_done (last_rd & (rd_ptr_q == BANK_B)),
        .len_q      (len_q),
        .full       (full_b),
        .ovr_pulse  (ovr_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= {{(LEN_W-1){1'b0}}, 1'b1};
            rcnt_q    <= '0;
            rd_ptr_q  <= BANK_A;
            overrun_q <= 1'b0;
            lines_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rcnt_q    <= rcnt_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            lines_q   <= lines_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_WAIT;
                ST_WAIT:  if (full_sel && proc_rdy) state_d = ST_DRAIN;
                ST_DRAIN: if (last_rd) state_d = ST_WAIT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        len_d = len_q;
        if (start) begin
            len_d = (packer_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : packer_len;
        end

        rcnt_d = rcnt_q;
        if (!enable || state_q == ST_WAIT || last_rd) begin
            rcnt_d = '0;
        end else if (rd_go) begin
            rcnt_d = rcnt_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = BANK_A;
        end else if (last_rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        overrun_d = start ? 1'b0 : (overrun_q | ovr_a | ovr_b);
        lines_d   = lines_q + {{(LCNT_W-1){1'b0}}, last_rd};
    end

    always_comb begin
        rd_a       = rd_go & (rd_ptr_q == BANK_A);
        rd_b       = rd_go & (rd_ptr_q == BANK_B);
        line_start = rd_go & (rcnt_q == '0);
        line_end   = last_rd;
        busy       = (state_q == ST_DRAIN);
        bank_sel   = rd_ptr_q;
        overrun    = overrun_q;
        lines_done = lines_q;
    end

endmodule
